// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/exec/writeback sequencer driving a 4-bit ALU + 16x4 RAM datapath.
module instr_sequencer #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4,
  parameter int IW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [IW-1:0]     prog_data,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] acc,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;
  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_acc;
  logic [IW-1:0]     r_ir;
  logic              w_alu;
  logic [2:0]        w_op;
  logic              w_to_wb;
  logic              w_jump;
  logic [PC_W-1:0]   w_pc_inc;
  assign w_alu    = r_ir[7];
  assign w_op     = r_ir[6:4];
  assign w_to_wb  = w_alu || w_op == OP_LD;
  assign w_jump   = !w_alu && (w_op == OP_JMP || (w_op == OP_JZ && r_acc == '0));
  assign w_pc_inc = r_pc + PC_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_acc   <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= start ? S_FETCH : S_IDLE;
        S_FETCH: begin
          r_ir    <= prog_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_to_wb) r_state <= S_WB;
          else if (w_op == OP_HALT) r_state <= S_HALT;
          else begin
            r_state <= S_FETCH;
            r_pc    <= w_jump ? PC_W'(r_ir[3:0]) : w_pc_inc;
            if (w_op == OP_LDI) r_acc <= DATA_W'(r_ir[3:0]);
          end
        end
        S_WB: begin
          r_acc   <= w_alu ? alu_result : ram_dout;
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign prog_addr  = r_pc;
  assign pc         = r_pc;
  assign acc        = r_acc;
  assign alu_A      = r_acc;
  assign alu_B      = DATA_W'(r_ir[3:0]);
  assign alu_opcode = r_ir[6:5];
  assign ram_din    = r_acc;
  assign ram_addr   = (r_state == S_EXEC || r_state == S_WB) ? DATA_W'(r_ir[3:0]) : '0;
  // rst gates the strobe combinationally so an in-flight store is dropped in the reset cycle
  assign ram_we     = !rst && r_state == S_EXEC && !w_alu && w_op == OP_ST;
  assign busy       = r_state == S_FETCH || r_state == S_EXEC || r_state == S_WB;
  assign halted     = r_state == S_HALT;
endmodule
